// File: rtl/bin_to_7seg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_7seg_seq
//  Description : Sequential binary-to-seven-segment formatter. A serial
//                shift-add-3 loop converts one input bit per clock to BCD.
//                Leading-zero blanking, a floating minus sign, decimal point
//                and overflow dashes are then applied. The result is a
//                registered, active-low segment vector for the display mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_7seg_seq #(
   parameter int N_DIGITS = 4,
   parameter int IN_WIDTH = 14,
   parameter int DP_POS   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [IN_WIDTH-1:0]   value,
   input  logic                  negative,
   input  logic                  decimal_en,
   input  logic                  blank_en,
   input  logic                  zero_dash,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [8*N_DIGITS-1:0] seg_out
);

   localparam int                  c_BCD_W     = 4 * N_DIGITS;
   localparam int                  c_CNT_W     = $clog2(IN_WIDTH);
   localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(IN_WIDTH - 1);
   localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [7:0]          c_SEG_DASH  = 8'h7F;
   localparam logic [7:0]          c_SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_ENCODE = 2'd2
   } state_t;

   state_t                r_state;
   logic [IN_WIDTH-1:0]   r_shift;
   logic [c_BCD_W-1:0]    r_bcd;
   logic                  r_carry;
   logic [c_CNT_W-1:0]    r_cnt;
   logic                  r_neg;
   logic                  r_dec;
   logic                  r_blank;
   logic                  r_zd;
   logic [8*N_DIGITS-1:0] r_stage_seg;
   logic                  r_stage_ovf;
   logic                  r_stage_vld;

   logic [c_BCD_W-1:0]    w_adj;
   logic                  w_ovf;
   logic                  w_zero;
   logic                  w_dash;
   logic                  w_seen;
   logic [3:0]            w_nib;
   logic [N_DIGITS-1:0]   w_keep;
   logic [N_DIGITS-1:0]   w_minus_oh;
   logic [8*N_DIGITS-1:0] w_fmt;

   // Active-low segment pattern {g,f,e,d,c,b,a,dp} for one decimal digit.
   function automatic logic [7:0] f_seg(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'h81;
         4'd1:    s = 8'hF3;
         4'd2:    s = 8'h49;
         4'd3:    s = 8'h61;
         4'd4:    s = 8'h33;
         4'd5:    s = 8'h25;
         4'd6:    s = 8'h05;
         4'd7:    s = 8'hF1;
         4'd8:    s = 8'h01;
         4'd9:    s = 8'h21;
         default: s = c_SEG_BLANK;
      endcase
      return s;
   endfunction

   // Add-3 correction: any nibble >= 5 would exceed 9 after doubling.
   genvar gi;
   generate
      for (gi = 0; gi < N_DIGITS; gi++) begin : g_adj
         assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                   (r_bcd[4*gi +: 4] + 4'd3) : r_bcd[4*gi +: 4];
      end
   endgenerate

   // Overflow / zero detection on the finished BCD result.
   always_comb begin
      w_ovf  = r_carry;
      w_zero = ~r_carry;
      w_nib  = 4'd0;
      for (int i = 0; i < N_DIGITS; i++) begin
         w_nib = r_bcd[4*i +: 4];
         if (w_nib > 4'd9) begin
            w_ovf = 1'b1;
         end
         if (w_nib != 4'd0) begin
            w_zero = 1'b0;
         end
      end
      // A negative number gives up the top digit to the minus sign.
      if (r_neg && (r_bcd[4*(N_DIGITS-1) +: 4] != 4'd0)) begin
         w_ovf = 1'b1;
      end
      w_dash = w_ovf | (w_zero & r_dec & r_zd);
   end

   // Which digits stay visible: a thermometer from digit 0 up to the leftmost shown digit.
   always_comb begin
      w_seen = 1'b0;
      w_keep = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         w_seen    = w_seen | (r_bcd[4*i +: 4] != 4'd0);
         w_keep[i] = w_seen | ~r_blank | (i == 0) | (r_dec & (i <= DP_POS));
      end
   end

   // Minus lands just left of the leftmost shown digit; when every digit is
   // shown it takes the top position, which is zero whenever overflow is clear.
   always_comb begin
      w_minus_oh = '0;
      for (int i = 1; i < N_DIGITS; i++) begin
         w_minus_oh[i] = ~w_keep[i] & w_keep[i-1];
      end
      w_minus_oh[N_DIGITS-1] = w_minus_oh[N_DIGITS-1] | w_keep[N_DIGITS-1];
   end

   // Assemble the formatted segment vector by rule priority.
   always_comb begin
      w_fmt = '1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (w_dash) begin
            w_fmt[8*i +: 8] = c_SEG_DASH;
         end else begin
            w_fmt[8*i +: 8] = w_keep[i] ? f_seg(r_bcd[4*i +: 4]) : c_SEG_BLANK;
            if (r_neg && w_minus_oh[i]) begin
               w_fmt[8*i +: 8] = c_SEG_DASH;
            end
            if (r_dec && (i == DP_POS)) begin
               w_fmt[8*i] = 1'b0;
            end
         end
      end
   end

   // Control FSM, serial converter datapath and registered display outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_bcd       <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_neg       <= 1'b0;
         r_dec       <= 1'b0;
         r_blank     <= 1'b0;
         r_zd        <= 1'b0;
         r_stage_seg <= '1;
         r_stage_ovf <= 1'b0;
         r_stage_vld <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overflow    <= 1'b0;
         seg_out     <= '1;
      end else begin
         done <= 1'b0;
         // Output stage: publish a formatted result one cycle after ENCODE,
         // while the FSM is already back in IDLE and can accept a new start.
         if (r_stage_vld) begin
            seg_out     <= r_stage_seg;
            overflow    <= r_stage_ovf;
            done        <= 1'b1;
            r_stage_vld <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_shift <= value;
                  r_neg   <= negative;
                  r_dec   <= decimal_en;
                  r_blank <= blank_en;
                  r_zd    <= zero_dash;
                  r_bcd   <= '0;
                  r_carry <= 1'b0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_bcd   <= {w_adj[c_BCD_W-2:0], r_shift[IN_WIDTH-1]};
               // Sticky so that any bit escaping the top nibble flags overflow.
               r_carry <= r_carry | w_adj[c_BCD_W-1];
               r_shift <= {r_shift[IN_WIDTH-2:0], 1'b0};
               if (r_cnt == c_CNT_LAST) begin
                  r_state <= S_ENCODE;
               end else begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            S_ENCODE: begin
               r_stage_seg <= w_fmt;
               r_stage_ovf <= w_ovf;
               r_stage_vld <= 1'b1;
               busy        <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
